// File: rtl/io_responder.sv
// io_responder: memory-mapped IO target on the LSU request/response bus.
// Owns the LEDR/LEDG/LCD/HEX output registers and serves synchronized switches.
// One transaction in flight, with WAIT_CYCLES extra access cycles before the response.
// Optional feature macro: IO_RESP_ERR_EN (when undefined, o_rsp_err is tied to 0).
module io_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_wren,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_bmask,
  output logic        o_rsp_vld,
  input  logic        i_rsp_rdy,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic [19:0] addr_q;
  logic        wren_q;
  logic [31:0] wdata_q;
  logic [3:0]  bmask_q;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex [8];
  logic [31:0] sync [SYNC_STAGES];
  logic        commit;
  logic        sel_ledr, sel_ledg, sel_hexlo, sel_hexhi, sel_lcd, sel_sw;
  logic        acc_err;
  logic [31:0] rd_data;
  logic        unused_bits;

  // Only the window/region nibbles of the address matter after acceptance.
  assign unused_bits = ^i_req_addr[11:0];

  assign commit    = (state == ACCESS) && (cnt == 4'd0);
  assign o_req_rdy = (state == IDLE);
  assign o_rsp_vld = (state == RESP);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, count down in ACCESS, hand off in RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req_vld) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (i_rsp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and wait-state counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      bmask_q <= '0;
      cnt     <= '0;
    end else if (state == IDLE && i_req_vld) begin
      addr_q  <= i_req_addr[31:12];
      wren_q  <= i_req_wren;
      wdata_q <= i_req_wdata;
      bmask_q <= i_req_bmask;
      cnt     <= 4'(WAIT_CYCLES);
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Address decode and read mux for the latched request.
  always_comb begin
    sel_ledr  = 1'b0;
    sel_ledg  = 1'b0;
    sel_hexlo = 1'b0;
    sel_hexhi = 1'b0;
    sel_lcd   = 1'b0;
    sel_sw    = 1'b0;
    rd_data   = '0;
    if (addr_q[19:4] == 16'h1000) begin
      case (addr_q[3:0])
        4'h0: sel_ledr  = 1'b1;
        4'h1: sel_ledg  = 1'b1;
        4'h2: sel_hexlo = 1'b1;
        4'h3: sel_hexhi = 1'b1;
        4'h4: sel_lcd   = 1'b1;
        4'h5: sel_sw    = 1'b1;
        default: ;
      endcase
    end
    acc_err = !(sel_ledr | sel_ledg | sel_hexlo | sel_hexhi | sel_lcd | sel_sw)
              || (wren_q && sel_sw);
    if (sel_ledr)  rd_data = ledr;
    if (sel_ledg)  rd_data = ledg;
    if (sel_hexlo) rd_data = {1'b0, hex[3], 1'b0, hex[2], 1'b0, hex[1], 1'b0, hex[0]};
    if (sel_hexhi) rd_data = {1'b0, hex[7], 1'b0, hex[6], 1'b0, hex[5], 1'b0, hex[4]};
    if (sel_lcd)   rd_data = lcd;
    if (sel_sw)    rd_data = sync[SYNC_STAGES-1];
  end

  // Response capture at commit; held stable through RESP.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= (wren_q || acc_err) ? '0 : rd_data;
      err_q   <= acc_err;
    end
  end

  assign o_rsp_rdata = rdata_q;
`ifdef IO_RESP_ERR_EN
  assign o_rsp_err = err_q;
`else
  assign o_rsp_err = 1'b0 & err_q;
`endif

  // Output registers: byte-enabled store at commit; SW and unmapped are never written.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr <= '0;
      ledg <= '0;
      lcd  <= '0;
      for (int unsigned i = 0; i < 8; i++) hex[i] <= 7'h7F;
    end else if (commit && wren_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bmask_q[i]) begin
          if (sel_ledr)  ledr[8*i +: 8] <= wdata_q[8*i +: 8];
          if (sel_ledg)  ledg[8*i +: 8] <= wdata_q[8*i +: 8];
          if (sel_lcd)   lcd[8*i +: 8]  <= wdata_q[8*i +: 8];
          if (sel_hexlo) hex[i]         <= wdata_q[8*i +: 7];
          if (sel_hexhi) hex[4+i]       <= wdata_q[8*i +: 7];
        end
      end
    end
  end

  // Switch synchronizer chain.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      sync[0] <= i_io_sw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;
  assign o_io_hex0 = hex[0];
  assign o_io_hex1 = hex[1];
  assign o_io_hex2 = hex[2];
  assign o_io_hex3 = hex[3];
  assign o_io_hex4 = hex[4];
  assign o_io_hex5 = hex[5];
  assign o_io_hex6 = hex[6];
  assign o_io_hex7 = hex[7];

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder (WAIT_CYCLES=1, SYNC_STAGES=2).
module tb_io_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [31:0] req_addr = '0;
  logic        req_wren = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_bmask = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] sw = '0;
  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int checks = 0;
  int errors = 0;

`ifdef IO_RESP_ERR_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  io_responder #(.WAIT_CYCLES(1), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_req_vld(req_vld), .o_req_rdy(req_rdy),
    .i_req_addr(req_addr), .i_req_wren(req_wren),
    .i_req_wdata(req_wdata), .i_req_bmask(req_bmask),
    .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .i_io_sw(sw),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_lcd(lcd),
    .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
    .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request with i_rsp_rdy high; returns response and edges to o_rsp_vld.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    req_vld = 1'b1; req_addr = a; req_wren = w; req_wdata = d; req_bmask = m;
    @(posedge clk); #1;
    req_vld = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_bmask = 4'hF;
    lat = 0;
    while (!rsp_vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    vecs[0]  = '{32'h1000_0000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{32'h1000_0000, 1'b0, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{32'h1000_2000, 1'b1, 32'hFFFF_FF3F, 4'h5, 32'h0,         1'b0};
    vecs[3]  = '{32'h1000_2000, 1'b0, 32'h0,         4'hF, 32'h7F7F_7F3F, 1'b0};
    vecs[4]  = '{32'h1000_1000, 1'b1, 32'h1234_5678, 4'h3, 32'h0,         1'b0};
    vecs[5]  = '{32'h1000_1000, 1'b0, 32'h0,         4'hF, 32'h0000_5678, 1'b0};
    vecs[6]  = '{32'h1000_4000, 1'b1, 32'hCAFE_F00D, 4'h0, 32'h0,         1'b0};
    vecs[7]  = '{32'h1000_4000, 1'b0, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[8]  = '{32'h1000_3004, 1'b1, 32'h8081_8283, 4'hF, 32'h0,         1'b0};
    vecs[9]  = '{32'h1000_3000, 1'b0, 32'h0,         4'hF, 32'h0001_0203, 1'b0};
    vecs[10] = '{32'h1000_6000, 1'b0, 32'h0,         4'hF, 32'h0,         E};
    vecs[11] = '{32'h1100_0000, 1'b1, 32'h0BAD_0BAD, 4'hF, 32'h0,         E};
    vecs[12] = '{32'h1000_0ABC, 1'b0, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};

    // Reset state
    #23;
    check("rst_rsp_vld", {31'b0, rsp_vld}, 32'h0);
    check("rst_req_rdy", {31'b0, req_rdy}, 32'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ledr", ledr, 32'h0);
    check("rst_ledg", ledg, 32'h0);
    check("rst_lcd", lcd, 32'h0);
    check("rst_hex", {4'h0, hex7, hex6, hex5, hex4}, {4'h0, {4{7'h7F}}});
    check("rst_hexlo", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, {4{7'h7F}}});
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'h0);

    // Table-driven transactions
    foreach (vecs[i]) begin
      txn(vecs[i].addr, vecs[i].wren, vecs[i].wdata, vecs[i].bmask, rd, er, lat);
      check($sformatf("v%0d_lat", i), lat, 2);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_idle", i), {30'b0, rsp_vld, req_rdy}, 32'h1);
    end
    check("ledr", ledr, 32'hDEAD_BEEF);
    check("ledg", ledg, 32'h0000_5678);
    check("lcd", lcd, 32'h0);
    check("hexlo", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h3F});
    check("hexhi", {4'h0, hex7, hex6, hex5, hex4}, {4'h0, 7'h00, 7'h01, 7'h02, 7'h03});

    // Switch path and store to SW
    @(negedge clk); sw = 32'h0000_A5A5;
    repeat (3) @(posedge clk);
    txn(32'h1000_5000, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("sw_rdata", rd, 32'h0000_A5A5);
    check("sw_err", {31'b0, er}, 32'h0);
    txn(32'h1000_5000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    check("sw_st_rdata", rd, 32'h0);
    check("sw_st_err", {31'b0, er}, {31'b0, E});
    check("sw_st_ledr", ledr, 32'hDEAD_BEEF);
    txn(32'h1000_5000, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("sw_rdata2", rd, 32'h0000_A5A5);

    // Response backpressure: held stable while i_rsp_rdy is low
    @(negedge clk);
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_addr = 32'h2000_0000; req_wren = 1'b0; req_bmask = 4'hF;
    @(posedge clk); #1; req_vld = 1'b0;
    lat = 0;
    while (!rsp_vld && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_lat", lat, 2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), {rsp_err, 29'b0, rsp_vld, req_rdy},
            {E, 29'b0, 1'b1, 1'b0});
      check($sformatf("bp_rdata%0d", k), rsp_rdata, 32'h0);
    end
    @(negedge clk); rsp_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'b0, rsp_vld, req_rdy}, 32'h1);

    // Asynchronous reset during ACCESS drops the pending store
    @(negedge clk);
    req_vld = 1'b1; req_addr = 32'h1000_1000; req_wren = 1'b1;
    req_wdata = 32'hFFFF_FFFF; req_bmask = 4'hF;
    @(posedge clk); #1; req_vld = 1'b0;
    check("ar_in_access", {31'b0, req_rdy}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_now", {30'b0, rsp_vld, req_rdy}, 32'h1);
    check("ar_ledr", ledr, 32'h0);
    check("ar_hex0", {25'b0, hex0}, 32'h7F);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_vld) seen++;
    end
    check("ar_no_rsp", seen, 0);
    check("ar_ledg", ledg, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end

endmodule
